// File: rtl/dom_and_sched_if.sv
// rtl/dom_and_sched_if.sv - request, randomness, gadget and response bundle for dom_and_sched
interface dom_and_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ*24-1:0] req_x_i;
    logic [NREQ*24-1:0] req_y_i;
    logic               rnd_valid_i;
    logic               rnd_ready_o;
    logic [23:0]        rnd_i;
    logic [23:0]        g_x_o;
    logic [23:0]        g_y_o;
    logic [23:0]        g_z_o;
    logic [23:0]        g_q_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [IDW-1:0]     rsp_id_o;
    logic [23:0]        rsp_q_o;

    // Environment side: requesters, randomness source, gadget and response sink.
    modport master (
        output req_valid_i, req_x_i, req_y_i, rnd_valid_i, rnd_i, g_q_i, rsp_ready_i,
        input  req_ready_o, rnd_ready_o, g_x_o, g_y_o, g_z_o, rsp_valid_o, rsp_id_o, rsp_q_o
    );

    // Scheduler side.
    modport slave (
        input  req_valid_i, req_x_i, req_y_i, rnd_valid_i, rnd_i, g_q_i, rsp_ready_i,
        output req_ready_o, rnd_ready_o, g_x_o, g_y_o, g_z_o, rsp_valid_o, rsp_id_o, rsp_q_o
    );
endinterface

// File: rtl/dom_and_sched.sv
// rtl/dom_and_sched.sv - round-robin scheduler for one shared 3-share DOM AND gadget (option: DOM_SCHED_ZEROIZE_EN)
module dom_and_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dom_and_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, RESP} state_t;

    state_t          state, state_nxt;
    logic [23:0]     op_x, op_y, op_z, rsp_q;
    logic [23:0]     sel_x, sel_y;
    logic [IDW-1:0]  op_id, rr_ptr, winner, rr_nxt;
    logic [NREQ-1:0] upper;
    logic            go;

    // Winner is the lowest request at or above rr_ptr, falling back to the lowest overall (wrap).
    always_comb begin
        upper  = '0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper[i] = bus.req_valid_i[i] && (i >= int'(rr_ptr));
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid_i[i]) winner = i[IDW-1:0];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (upper[i]) winner = i[IDW-1:0];
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == i[IDW-1:0]) begin
                sel_x = bus.req_x_i[24*i +: 24];
                sel_y = bus.req_y_i[24*i +: 24];
            end
        end
    end

    assign rr_nxt = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

    // A grant needs a requester, fresh randomness and a free (or just-freed) gadget slot.
    assign go = !rst_i && (|bus.req_valid_i) && bus.rnd_valid_i &&
                ((state == IDLE) || ((state == RESP) && bus.rsp_ready_i));

    // Next-state logic: ISSUE and HOLD are fixed single cycles, RESP waits for the sink.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready_i) state_nxt = go ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One-hot grant pulse, only in a go cycle.
    always_comb begin
        bus.req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready_o[i] = go && (winner == i[IDW-1:0]);
        end
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            op_x   <= '0;
            op_y   <= '0;
            op_z   <= '0;
            op_id  <= '0;
            rsp_q  <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                rr_ptr <= rr_nxt;
                op_x   <= sel_x;
                op_y   <= sel_y;
                op_z   <= bus.rnd_i;
                op_id  <= winner;
            end
`ifdef DOM_SCHED_ZEROIZE_EN
            else if (state == HOLD) begin
                // Result is captured this edge; operands and Z are no longer needed.
                op_x <= '0;
                op_y <= '0;
                op_z <= '0;
            end
`endif
            if (state == HOLD) begin
                // Same-domain terms still see the held operands, so Q is complete here.
                rsp_q <= bus.g_q_i;
            end
`ifdef DOM_SCHED_ZEROIZE_EN
            else if ((state == RESP) && bus.rsp_ready_i && !go) begin
                rsp_q <= '0;
            end
`endif
        end
    end

    // Z reaches the gadget only in ISSUE so each random word feeds exactly one cross-term capture.
    assign bus.g_x_o       = op_x;
    assign bus.g_y_o       = op_y;
    assign bus.g_z_o       = (state == ISSUE) ? op_z : '0;
    assign bus.rnd_ready_o = go;
    assign bus.rsp_valid_o = (state == RESP);
    assign bus.rsp_id_o    = op_id;
    assign bus.rsp_q_o     = rsp_q;
endmodule
